// File: rtl/uart_pkg.sv
// Shared character constants and line-buffer state encoding for the UART path.
package uart_pkg;

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;
  localparam logic [7:0] CHAR_BS = 8'h08;

  typedef enum logic [1:0] {
    COLLECT,
    EMIT,
    EOL_CR,
    EOL_LF
  } line_state_t;

endpackage

// File: rtl/uart_line_buf_if.sv
// Receive/transmit byte streams between the UART and the line buffer.
interface uart_line_buf_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output rx_data, rx_valid, tx_ready,
    input  rx_ready, tx_data, tx_valid
  );

  modport slave (
    input  rx_data, rx_valid, tx_ready,
    output rx_ready, tx_data, tx_valid
  );

endinterface

// File: rtl/uart_line_ram.sv
// Line storage: synchronous write, asynchronous read, contents not reset.
module uart_line_ram #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          uart_clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // Write port
  always_ff @(posedge uart_clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_line_buf.sv
// Line-editing echo stage: collects rx bytes with backspace, replays line + CR LF.
module uart_line_buf
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH    = 64,
  parameter logic [7:0]  EOL_CHAR = 8'h0D,
  localparam int unsigned CW      = $clog2(DEPTH + 1)
) (
  input  logic          uart_clk,
  input  logic          uart_rst,
  uart_line_buf_if.slave bus,
  output logic [CW-1:0] line_len,
  output logic          overflow,
  output logic          busy
);

  localparam int unsigned AW = $clog2(DEPTH);

  line_state_t   state;
  logic [CW-1:0] count;
  logic [CW-1:0] rd_ptr;
  logic [7:0]    rd_data;
  logic          rx_fire;
  logic          tx_fire;
  logic          is_print;
  logic          wr_en;
  logic          full;

  // Handshake and byte classification
  always_comb begin
    rx_fire  = bus.rx_valid && bus.rx_ready;
    tx_fire  = bus.tx_valid && bus.tx_ready;
    is_print = (bus.rx_data != EOL_CHAR) && (bus.rx_data != CHAR_LF) &&
               (bus.rx_data != CHAR_BS);
    full     = (count == CW'(DEPTH));
    wr_en    = rx_fire && is_print && !full;
  end

  uart_line_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .uart_clk (uart_clk),
    .we       (wr_en),
    .waddr    (count[AW-1:0]),
    .wdata    (bus.rx_data),
    .raddr    (rd_ptr[AW-1:0]),
    .rdata    (rd_data)
  );

  // Line FSM with registered handshake and status outputs
  always_ff @(posedge uart_clk or negedge uart_rst) begin
    if (!uart_rst) begin
      state        <= COLLECT;
      count        <= '0;
      rd_ptr       <= '0;
      bus.rx_ready <= 1'b0;
      bus.tx_valid <= 1'b0;
      bus.tx_data  <= 8'h00;
      overflow     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      overflow <= 1'b0;
      case (state)
        COLLECT: begin
          bus.rx_ready <= 1'b1;
          if (rx_fire) begin
            if (bus.rx_data == EOL_CHAR) begin
              bus.rx_ready <= 1'b0;
              bus.tx_valid <= 1'b1;
              busy         <= 1'b1;
              if (count == '0) begin
                bus.tx_data <= CHAR_CR;
                state       <= EOL_CR;
              end else begin
                // rd_ptr rests at 0 while collecting, so rd_data is mem[0]
                bus.tx_data <= rd_data;
                rd_ptr      <= CW'(1);
                state       <= EMIT;
              end
            end else if (bus.rx_data == CHAR_LF) begin
              // dropped so CR LF terminals do not produce an empty second line
            end else if (bus.rx_data == CHAR_BS) begin
              if (count != '0) count <= count - CW'(1);
            end else if (full) begin
              overflow <= 1'b1;
            end else begin
              count <= count + CW'(1);
            end
          end
        end
        EMIT: begin
          if (tx_fire) begin
            if (rd_ptr == count) begin
              bus.tx_data <= CHAR_CR;
              state       <= EOL_CR;
            end else begin
              bus.tx_data <= rd_data;
              rd_ptr      <= rd_ptr + CW'(1);
            end
          end
        end
        EOL_CR: begin
          if (tx_fire) begin
            bus.tx_data <= CHAR_LF;
            state       <= EOL_LF;
          end
        end
        EOL_LF: begin
          if (tx_fire) begin
            bus.tx_valid <= 1'b0;
            bus.rx_ready <= 1'b1;
            busy         <= 1'b0;
            count        <= '0;
            rd_ptr       <= '0;
            state        <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  assign line_len = count;

endmodule

// File: tb/tb_uart_line_buf.sv
// Directed bench for uart_line_buf with a byte-stream scoreboard.
module tb_uart_line_buf;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          uart_clk;
  logic          uart_rst;
  logic [CW-1:0] line_len;
  logic          overflow;
  logic          busy;

  uart_line_buf_if bus ();

  uart_line_buf #(.DEPTH(DEPTH), .EOL_CHAR(8'h0D)) dut (
    .uart_clk (uart_clk),
    .uart_rst (uart_rst),
    .bus      (bus),
    .line_len (line_len),
    .overflow (overflow),
    .busy     (busy)
  );

  int checks = 0;
  int passed = 0;
  int ovf_cnt = 0;

  logic [7:0] sb   [$];
  logic [7:0] mbuf [$];
  logic       mod_ovf;

  logic       stall_prev = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  initial begin
    uart_clk = 1'b0;
    forever #5 uart_clk = ~uart_clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  // Reference line model: updates the line and pushes expected tx bytes on CR
  task automatic model(input logic [7:0] b);
    mod_ovf = 1'b0;
    if (b == 8'h0D) begin
      foreach (mbuf[i]) sb.push_back(mbuf[i]);
      sb.push_back(8'h0D);
      sb.push_back(8'h0A);
      mbuf.delete();
    end else if (b == 8'h0A) begin
    end else if (b == 8'h08) begin
      if (mbuf.size() > 0) void'(mbuf.pop_back());
    end else if (mbuf.size() < DEPTH) begin
      mbuf.push_back(b);
    end else begin
      mod_ovf = 1'b1;
    end
  endtask

  // Present one byte until accepted; called and returns at posedge+1
  task automatic send(input logic [7:0] b);
    int n;
    model(b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    n = 0;
    while (n < 2000) begin
      @(negedge uart_clk);
      if (bus.rx_ready) break;
      n++;
    end
    check("rx_accept_timeout", 32'(n < 2000), 32'(1));
    @(posedge uart_clk);
    #1;
    bus.rx_valid = 1'b0;
    if (b == 8'h0D) begin
      check("rx_ready_after_eol", 32'(bus.rx_ready), 32'(0));
      check("busy_after_eol", 32'(busy), 32'(1));
    end else begin
      check("line_len", 32'(line_len), 32'(mbuf.size()));
      check("overflow_pulse", 32'(overflow), 32'(mod_ovf));
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (n < 1000) begin
      @(negedge uart_clk);
      if (!busy && sb.size() == 0) break;
      n++;
    end
    check("idle_busy", 32'(busy), 32'(0));
    check("sb_empty", 32'(sb.size()), 32'(0));
    @(posedge uart_clk);
    #1;
  endtask

  // Output monitor: scoreboard pops, stall stability, rx backpressure, overflow count
  always @(negedge uart_clk) begin
    if (uart_rst) begin
      if (stall_prev) begin
        check("stall_valid_held", 32'(bus.tx_valid), 32'(1));
        check("stall_data_held", 32'(bus.tx_data), 32'(prev_data));
      end
      stall_prev = bus.tx_valid && !bus.tx_ready;
      prev_data  = bus.tx_data;
      if (bus.tx_valid && bus.tx_ready) begin
        checks++;
        assert (sb.size() > 0) passed++;
        else $error("FAIL tx_unexpected: observed %0h expected no byte", bus.tx_data);
        if (sb.size() > 0) check("tx_byte", 32'(bus.tx_data), 32'(sb.pop_front()));
      end
      if (busy) check("rx_ready_in_replay", 32'(bus.rx_ready), 32'(0));
      if (overflow) ovf_cnt++;
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    int n;
    uart_rst     = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b1;
    repeat (3) @(posedge uart_clk);
    #1;
    check("rst_rx_ready", 32'(bus.rx_ready), 32'(0));
    check("rst_tx_valid", 32'(bus.tx_valid), 32'(0));
    check("rst_tx_data", 32'(bus.tx_data), 32'(0));
    check("rst_overflow", 32'(overflow), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_line_len", 32'(line_len), 32'(0));
    uart_rst = 1'b1;
    @(posedge uart_clk);
    #1;
    check("rx_ready_rise", 32'(bus.rx_ready), 32'(1));

    // "Hi" CR
    send(8'h48); send(8'h69); send(8'h0D);
    wait_idle();

    // backspace editing
    send(8'h61); send(8'h62); send(8'h63); send(8'h08); send(8'h64); send(8'h0D);
    wait_idle();

    // backspace on empty line, then empty line
    send(8'h08); send(8'h0D);
    wait_idle();
    check("empty_len", 32'(line_len), 32'(0));

    // overflow on the fifth printable byte
    n = ovf_cnt;
    send(8'h41); send(8'h42); send(8'h43); send(8'h44); send(8'h45); send(8'h0D);
    wait_idle();
    check("ovf_count", 32'(ovf_cnt - n), 32'(1));

    // random tx stalls during replay
    bus.tx_ready = 1'b0;
    send(8'h78); send(8'h79); send(8'h7A); send(8'h0D);
    for (int i = 0; i < 60 && busy; i++) begin
      repeat ($urandom_range(0, 20)) @(posedge uart_clk);
      #1;
      bus.tx_ready = 1'b1;
      @(posedge uart_clk);
      #1;
      bus.tx_ready = 1'b0;
    end
    check("stall_replay_done", 32'(busy), 32'(0));
    bus.tx_ready = 1'b1;
    wait_idle();

    // reset in the middle of a stalled replay
    bus.tx_ready = 1'b0;
    send(8'h70); send(8'h71); send(8'h0D);
    repeat (3) @(posedge uart_clk);
    #2;
    check("pre_rst_tx_valid", 32'(bus.tx_valid), 32'(1));
    uart_rst = 1'b0;
    #1;
    check("mid_rst_tx_valid", 32'(bus.tx_valid), 32'(0));
    check("mid_rst_busy", 32'(busy), 32'(0));
    check("mid_rst_tx_data", 32'(bus.tx_data), 32'(0));
    check("mid_rst_line_len", 32'(line_len), 32'(0));
    sb.delete();
    mbuf.delete();
    repeat (2) @(posedge uart_clk);
    #1;
    uart_rst = 1'b1;
    bus.tx_ready = 1'b1;
    @(posedge uart_clk);
    #1;
    check("post_rst_rx_ready", 32'(bus.rx_ready), 32'(1));
    send(8'h6B); send(8'h0D);
    wait_idle();

    // CR LF from terminal: single CR LF echo
    send(8'h0D); send(8'h0A);
    wait_idle();
    repeat (10) @(posedge uart_clk);
    #1;
    check("crlf_len", 32'(line_len), 32'(0));
    check("crlf_no_echo", 32'(bus.tx_valid), 32'(0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
